// File: rtl/aes_inv_key_sched.sv
// Iterative inverse AES-128 key schedule: loaded with round key 10, emits keys 10..0 one per handshake.
// Holds the S-box and RotWord helpers alongside the controller so the block is self-contained.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign s = SBOX[a];
endmodule

module aes_rotword (
  input  logic [0:31] w,
  output logic [0:31] r
);
  assign r = {w[8:31], w[0:7]};
endmodule

// state | meaning
// IDLE  | waiting for load; outputs hold last key/index, out_valid=0
// EMIT  | round_key/round_idx presented; advance one round per handshake
module aes_inv_key_sched #(
  parameter int NROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [0:127] key_in,
  output logic         busy,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] round_key,
  output logic [3:0]   round_idx,
  output logic         done
);
  typedef enum logic {IDLE, EMIT} state_t;
  state_t state;

  logic [0:31] y0, y1, y2, y3;
  logic [0:31] w0, w1, w2, w3;
  logic [0:31] rot, sub;
  logic [7:0]  rcon;
  logic [0:127] prev_key;

  assign y0 = round_key[0:31];
  assign y1 = round_key[32:63];
  assign y2 = round_key[64:95];
  assign y3 = round_key[96:127];

  assign w3 = y3 ^ y2;
  assign w2 = y2 ^ y1;
  assign w1 = y1 ^ y0;

  aes_rotword u_rotword (.w(w3), .r(rot));

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (.a(rot[8*i +: 8]), .s(sub[8*i +: 8]));
  end

  always_comb begin
    rcon = 8'h00;
    case (round_idx)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign w0       = y0 ^ sub ^ {rcon, 24'h000000};
  assign prev_key = {w0, w1, w2, w3};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      round_key <= '0;
      round_idx <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            round_key <= key_in;
            round_idx <= 4'(NROUNDS);
            busy      <= 1'b1;
            out_valid <= 1'b1;
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (round_idx != 4'd0) begin
              round_key <= prev_key;
              round_idx <= round_idx - 4'd1;
            end else begin
              // last key consumed; key/index keep their final values
              state     <= IDLE;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Scoreboard bench for aes_inv_key_sched: stimulus pushes expected keys, a negedge monitor pops and compares.
module tb_aes_inv_key_sched;
  logic         clk = 1'b0;
  logic         rst, load, out_ready;
  logic [0:127] key_in;
  logic         busy, out_valid, done;
  logic [0:127] round_key;
  logic [3:0]   round_idx;

  aes_inv_key_sched #(.NROUNDS(10)) dut (
    .clk(clk), .rst(rst), .load(load), .key_in(key_in), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .round_key(round_key),
    .round_idx(round_idx), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]   idx;
    logic [0:127] key;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;

  // FIPS-197 appendix A.1 round keys 0..10
  localparam logic [0:10][0:127] FIPS = {
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  localparam logic [0:255][7:0] SB_TB = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  localparam logic [1:10][7:0] RC = {8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                     8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  task automatic chk(input string name, input logic [0:127] act, input logic [0:127] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%032h required=%032h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [0:31] sub_rot(input logic [0:31] w);
    return {SB_TB[w[8:15]], SB_TB[w[16:23]], SB_TB[w[24:31]], SB_TB[w[0:7]]};
  endfunction

  task automatic push_fips();
    for (int r = 10; r >= 0; r--) sb.push_back('{idx: 4'(r), key: FIPS[r]});
  endtask

  // forward expansion of a cipher key; pushes rounds 10..0, returns round 10
  task automatic push_forward(input logic [0:127] k, output logic [0:127] k10);
    logic [0:127] rk [0:10];
    logic [0:31]  t, n0, n1, n2, n3;
    rk[0] = k;
    for (int r = 1; r <= 10; r++) begin
      t  = sub_rot(rk[r-1][96:127]) ^ {RC[r], 24'h000000};
      n0 = rk[r-1][0:31] ^ t;
      n1 = rk[r-1][32:63] ^ n0;
      n2 = rk[r-1][64:95] ^ n1;
      n3 = rk[r-1][96:127] ^ n2;
      rk[r] = {n0, n1, n2, n3};
    end
    for (int r = 10; r >= 0; r--) sb.push_back('{idx: 4'(r), key: rk[r]});
    k10 = rk[10];
  endtask

  // monitor
  logic         done_due = 1'b0;
  logic         hold_v = 1'b0;
  logic [0:127] hold_key;
  logic [3:0]   hold_idx;
  exp_t         e;

  always @(negedge clk) begin
    if (rst) begin
      done_due = 1'b0;
      hold_v   = 1'b0;
    end else begin
      chk("done", {127'b0, done}, {127'b0, done_due});
      done_due = 1'b0;
      if (out_valid && hold_v) begin
        chk("hold_key", round_key, hold_key);
        chk("hold_idx", {124'b0, round_idx}, {124'b0, hold_idx});
      end
      hold_v = 1'b0;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", {124'b0, round_idx}, 128'hffff);
        end else begin
          e = sb.pop_front();
          chk("idx", {124'b0, round_idx}, {124'b0, e.idx});
          chk("key", round_key, e.key);
          if (e.idx == 4'd0) done_due = 1'b1;
        end
      end else if (out_valid) begin
        hold_v   = 1'b1;
        hold_key = round_key;
        hold_idx = round_idx;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [0:127] k);
    load   = 1'b1;
    key_in = k;
    tick();
    load   = 1'b0;
    key_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_done(input bit rnd);
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      tick();
      if (done) seen = 1'b1;
    end
    out_ready = 1'b1;
    chk("wait_done_timeout", {127'b0, seen}, 128'd1);
  endtask

  task automatic wait_idx(input logic [3:0] n);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (out_valid && round_idx == n) seen = 1'b1;
      else tick();
    end
    chk("wait_idx_timeout", {127'b0, seen}, 128'd1);
  endtask

  logic [0:127] k10;

  initial begin
    rst = 1'b1; load = 1'b0; out_ready = 1'b0; key_in = '0;
    tick(); tick();
    chk("rst_valid", {127'b0, out_valid}, 128'd0);
    chk("rst_busy", {127'b0, busy}, 128'd0);
    chk("rst_key", round_key, 128'd0);
    chk("rst_idx", {124'b0, round_idx}, 128'd0);
    rst = 1'b0;
    tick();

    // basic, continuous ready
    out_ready = 1'b1;
    push_fips();
    do_load(FIPS[10]);
    chk("first_valid", {127'b0, out_valid}, 128'd1);
    chk("first_busy", {127'b0, busy}, 128'd1);
    wait_done(1'b0);
    tick();
    chk("idle_valid", {127'b0, out_valid}, 128'd0);
    chk("idle_busy", {127'b0, busy}, 128'd0);
    chk("idle_key_held", round_key, FIPS[0]);

    // backpressure
    push_fips();
    do_load(FIPS[10]);
    wait_done(1'b1);

    // load ignored at idx 6, then load during done cycle
    push_fips();
    do_load(FIPS[10]);
    wait_idx(4'd6);
    load = 1'b1; key_in = 128'h0123456789abcdef0123456789abcdef;
    tick();
    load = 1'b0;
    wait_done(1'b0);
    push_forward(128'h000102030405060708090a0b0c0d0e0f, k10);
    do_load(k10);
    chk("done_cycle_load_valid", {127'b0, out_valid}, 128'd1);
    chk("done_cycle_load_idx", {124'b0, round_idx}, 128'd10);
    wait_done(1'b0);

    // mid-sequence reset at idx 4
    push_fips();
    do_load(FIPS[10]);
    wait_idx(4'd4);
    out_ready = 1'b0;
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", {127'b0, out_valid}, 128'd0);
    chk("mid_rst_busy", {127'b0, busy}, 128'd0);
    chk("mid_rst_key", round_key, 128'd0);
    chk("mid_rst_done", {127'b0, done}, 128'd0);
    rst = 1'b0;
    sb.delete();
    tick(); tick();
    out_ready = 1'b1;
    push_fips();
    do_load(FIPS[10]);
    chk("restart_idx", {124'b0, round_idx}, 128'd10);
    wait_done(1'b0);

    // round trip on random keys
    for (int n = 0; n < 100; n++) begin
      push_forward({$urandom, $urandom, $urandom, $urandom}, k10);
      do_load(k10);
      wait_done(n[0]);
    end

    tick(); tick();
    chk("scoreboard_empty", 128'(sb.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
